// File: rtl/adc_seq_model.sv
// Photodiode ADC acquisition chain model: delayed AD_sp/AD_trig pulses, then a
// divided ADC clock streaming a burst of multi-channel sample words.
`timescale 1ns/1ps
module adc_seq_model #(
  parameter int DATA_W    = 16,
  parameter int CH_N      = 1,
  parameter int DELAY_CYC = 140,
  parameter int SP_CYC    = 10,
  parameter int TRIG_CYC  = 5,
  parameter int CLK_DIV   = 20,
  parameter int N_SAMPLES = 518,
  localparam int CH_W     = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic              clk_200MHz_i,
  input  logic              rst_i,
  input  logic              signal_to_diods_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] pattern_i,
  output logic              AD_sp_o,
  output logic              AD_trig_o,
  output logic              clk_10M_adc_o,
  output logic [DATA_W-1:0] ADC_data_o,
  output logic [CH_W-1:0]   ADC_ch_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  // state | meaning
  // IDLE  | waiting for a trigger edge
  // WAIT  | programmable delay before AD_sp
  // SP    | AD_sp high
  // TRIG  | AD_sp and AD_trig high
  // XFER  | ADC clock running, words streamed
  // DONE  | one-cycle end-of-burst pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SP, S_TRIG, S_XFER, S_DONE
  } state_t;

  localparam int N_WORDS = N_SAMPLES * CH_N;
  localparam int TMR_MAX = (DELAY_CYC > SP_CYC)
                           ? ((DELAY_CYC > TRIG_CYC) ? DELAY_CYC : TRIG_CYC)
                           : ((SP_CYC > TRIG_CYC) ? SP_CYC : TRIG_CYC);
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int WL_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [TMR_W-1:0] DLY_LD  = TMR_W'((DELAY_CYC > 0) ? DELAY_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] SP_LD   = TMR_W'(SP_CYC - 1);
  localparam logic [TMR_W-1:0] TRIG_LD = TMR_W'(TRIG_CYC - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF = PH_W'(CLK_DIV / 2);
  localparam logic [WL_W-1:0]  WL_LD   = WL_W'(N_WORDS - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CH_N - 1);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("adc_seq_model: CLK_DIV must be even and >= 2");
  end
  if (CH_N < 1 || CH_N > 8) begin : g_bad_ch_n
    $error("adc_seq_model: CH_N must be 1..8");
  end
  if (SP_CYC < 1 || TRIG_CYC < 1 || N_SAMPLES < 1 || DELAY_CYC < 0) begin : g_bad_cyc
    $error("adc_seq_model: SP_CYC, TRIG_CYC, N_SAMPLES must be >= 1");
  end

  state_t              state_q, state_d;
  logic                trig_q;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [WL_W-1:0]     wl_q, wl_d;
  logic [DATA_W-1:0]   wcnt_q, wcnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic                ovr_q, ovr_d;
  logic                edge_det;

  function automatic logic [DATA_W-1:0] word_val(input logic [1:0] m,
                                                 input logic [DATA_W-1:0] p,
                                                 input logic [DATA_W-1:0] w);
    case (m)
      2'd1:    return p;
      2'd2:    return p ^ w;
      default: return w;
    endcase
  endfunction

  assign edge_det = signal_to_diods_i & ~trig_q;

  always_ff @(posedge clk_200MHz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      tmr_q   <= '0;
      ph_q    <= '0;
      wl_q    <= '0;
      wcnt_q  <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      pat_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= signal_to_diods_i;
      tmr_q   <= tmr_d;
      ph_q    <= ph_d;
      wl_q    <= wl_d;
      wcnt_q  <= wcnt_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ph_d    = ph_q;
    wl_d    = wl_q;
    wcnt_d  = wcnt_q;
    ch_d    = ch_q;
    data_d  = data_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    ovr_d   = ovr_q;

    // Any edge outside IDLE (DONE included) is dropped and flagged.
    if (edge_det && state_q != S_IDLE) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (edge_det) begin
          mode_d = mode_i;
          pat_d  = pattern_i;
          wcnt_d = '0;
          if (DELAY_CYC == 0) begin
            state_d = S_SP;
            tmr_d   = SP_LD;
          end else begin
            state_d = S_WAIT;
            tmr_d   = DLY_LD;
          end
        end
      end
      S_WAIT: begin
        if (tmr_q == '0) begin
          state_d = S_SP;
          tmr_d   = SP_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_SP: begin
        if (tmr_q == '0) begin
          state_d = S_TRIG;
          tmr_d   = TRIG_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_TRIG: begin
        if (tmr_q == '0) begin
          state_d = S_XFER;
          ph_d    = '0;
          wl_d    = WL_LD;
          ch_d    = '0;
          data_d  = word_val(mode_q, pat_q, wcnt_q);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_XFER: begin
        if (ph_q == PH_LAST) begin
          ph_d   = '0;
          wcnt_d = wcnt_q + DATA_W'(1);
          if (wl_q == '0) begin
            state_d = S_DONE;
          end else begin
            wl_d   = wl_q - WL_W'(1);
            ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
            data_d = word_val(mode_q, pat_q, wcnt_q + DATA_W'(1));
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign AD_sp_o       = (state_q == S_SP) || (state_q == S_TRIG);
  assign AD_trig_o     = (state_q == S_TRIG);
  assign clk_10M_adc_o = (state_q == S_XFER) && (ph_q >= PH_HALF);
  assign data_valid_o  = (state_q == S_XFER) && (ph_q == PH_HALF);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign overrun_o     = ovr_q;
  assign ADC_data_o    = data_q;
  assign ADC_ch_o      = ch_q;

endmodule

// File: tb/tb_adc_seq_model.sv
// Directed bench for adc_seq_model: four parameter sets driven from one linear
// sequence; cycle k counts clocks after the trigger edge cycle.
`timescale 1ns/1ps
module tb_adc_seq_model;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #2.5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: CH_N=1 N=3; b: CH_N=2 N=2; c: DATA_W=4 N=18; d: DELAY_CYC=0 N=1
  logic trig_a = 0, trig_b = 0, trig_c = 0, trig_d = 0;
  logic [1:0] mode_a = 0, mode_b = 0, mode_c = 0, mode_d = 0;
  logic [15:0] pat_a = 0, pat_b = 0, pat_d = 0;
  logic [3:0]  pat_c = 0;
  logic sp_a, trg_a, aclk_a, vld_a, busy_a, done_a, ovr_a, ch_a;
  logic sp_b, trg_b, aclk_b, vld_b, busy_b, done_b, ovr_b, ch_b;
  logic sp_c, trg_c, aclk_c, vld_c, busy_c, done_c, ovr_c, ch_c;
  logic sp_d, trg_d, aclk_d, vld_d, busy_d, done_d, ovr_d, ch_d;
  logic [15:0] data_a, data_b, data_d;
  logic [3:0]  data_c;

  adc_seq_model #(.DATA_W(16), .CH_N(1), .DELAY_CYC(4), .SP_CYC(2), .TRIG_CYC(1),
                  .CLK_DIV(4), .N_SAMPLES(3)) u_a (
    .clk_200MHz_i(clk), .rst_i(rst), .signal_to_diods_i(trig_a), .mode_i(mode_a),
    .pattern_i(pat_a), .AD_sp_o(sp_a), .AD_trig_o(trg_a), .clk_10M_adc_o(aclk_a),
    .ADC_data_o(data_a), .ADC_ch_o(ch_a), .data_valid_o(vld_a), .busy_o(busy_a),
    .done_o(done_a), .overrun_o(ovr_a));

  adc_seq_model #(.DATA_W(16), .CH_N(2), .DELAY_CYC(4), .SP_CYC(2), .TRIG_CYC(1),
                  .CLK_DIV(4), .N_SAMPLES(2)) u_b (
    .clk_200MHz_i(clk), .rst_i(rst), .signal_to_diods_i(trig_b), .mode_i(mode_b),
    .pattern_i(pat_b), .AD_sp_o(sp_b), .AD_trig_o(trg_b), .clk_10M_adc_o(aclk_b),
    .ADC_data_o(data_b), .ADC_ch_o(ch_b), .data_valid_o(vld_b), .busy_o(busy_b),
    .done_o(done_b), .overrun_o(ovr_b));

  adc_seq_model #(.DATA_W(4), .CH_N(1), .DELAY_CYC(4), .SP_CYC(2), .TRIG_CYC(1),
                  .CLK_DIV(4), .N_SAMPLES(18)) u_c (
    .clk_200MHz_i(clk), .rst_i(rst), .signal_to_diods_i(trig_c), .mode_i(mode_c),
    .pattern_i(pat_c), .AD_sp_o(sp_c), .AD_trig_o(trg_c), .clk_10M_adc_o(aclk_c),
    .ADC_data_o(data_c), .ADC_ch_o(ch_c), .data_valid_o(vld_c), .busy_o(busy_c),
    .done_o(done_c), .overrun_o(ovr_c));

  adc_seq_model #(.DATA_W(16), .CH_N(1), .DELAY_CYC(0), .SP_CYC(2), .TRIG_CYC(1),
                  .CLK_DIV(4), .N_SAMPLES(1)) u_d (
    .clk_200MHz_i(clk), .rst_i(rst), .signal_to_diods_i(trig_d), .mode_i(mode_d),
    .pattern_i(pat_d), .AD_sp_o(sp_d), .AD_trig_o(trg_d), .clk_10M_adc_o(aclk_d),
    .ADC_data_o(data_d), .ADC_ch_o(ch_d), .data_valid_o(vld_d), .busy_o(busy_d),
    .done_o(done_d), .overrun_o(ovr_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp3 [3];
  int vc;
  int j;

  initial begin
    exp3[0] = 16'h00FF; exp3[1] = 16'h00FE; exp3[2] = 16'h00FD;

    tick(); tick();
    chk("rst_a", {sp_a, trg_a, aclk_a, data_a, ch_a, vld_a, busy_a, done_a, ovr_a}, 0);
    chk("rst_b", {sp_b, trg_b, aclk_b, data_b, ch_b, vld_b, busy_b, done_b, ovr_b}, 0);
    chk("rst_c", {sp_c, trg_c, aclk_c, data_c, ch_c, vld_c, busy_c, done_c, ovr_c}, 0);
    chk("rst_d", {sp_d, trg_d, aclk_d, data_d, ch_d, vld_d, busy_d, done_d, ovr_d}, 0);
    rst = 0;
    tick();

    // 1: basic timing, ramp
    trig_a = 1; tick();
    for (int k = 1; k <= 21; k++) begin
      chk("t1_busy", busy_a, k <= 20);
      chk("t1_sp", sp_a, k >= 5 && k <= 7);
      chk("t1_trig", trg_a, k == 7);
      chk("t1_adcclk", aclk_a, k inside {10, 11, 14, 15, 18, 19});
      chk("t1_valid", vld_a, k inside {10, 14, 18});
      chk("t1_done", done_a, k == 20);
      if (k inside {10, 14, 18}) chk("t1_data", data_a, (k - 10) / 4);
      tick();
    end
    trig_a = 0;
    chk("t1_hold", data_a, 2);
    chk("t1_ovr", ovr_a, 0);

    // 2: two channels, constant pattern
    mode_b = 1; pat_b = 16'hA5A5; trig_b = 1; tick();
    vc = 0;
    for (int k = 1; k <= 25; k++) begin
      if (vld_b) vc++;
      chk("t2_valid", vld_b, k inside {10, 14, 18, 22});
      if (k inside {10, 14, 18, 22}) begin
        chk("t2_data", data_b, 16'hA5A5);
        chk("t2_ch", ch_b, ((k - 10) / 4) % 2);
      end
      chk("t2_done", done_b, k == 24);
      chk("t2_busy", busy_b, k <= 24);
      tick();
    end
    trig_b = 0;
    chk("t2_nvalid", vc, 4);

    // 3: XOR pattern, mode change mid-burst ignored
    tick();
    mode_a = 2; pat_a = 16'h00FF; trig_a = 1; tick();
    for (int k = 1; k <= 21; k++) begin
      if (k == 12) mode_a = 1;
      if (k inside {10, 14, 18}) chk("t3_data", data_a, exp3[(k - 10) / 4]);
      tick();
    end
    trig_a = 0; mode_a = 0;

    // 4: re-edge during WAIT, level held through DONE
    tick();
    chk("t4_ovr0", ovr_a, 0);
    trig_a = 1; tick();
    for (int k = 1; k <= 22; k++) begin
      chk("t4_ovr", ovr_a, k >= 4);
      chk("t4_busy", busy_a, k <= 20);
      chk("t4_done", done_a, k == 20);
      if (k == 2) trig_a = 0;
      if (k == 3) trig_a = 1;
      tick();
    end
    chk("t4_noretrig", busy_a, 0);
    trig_a = 0; tick();
    trig_a = 1; tick();
    chk("t4_newburst", busy_a, 1);
    chk("t4_ovr_sticky", ovr_a, 1);

    // 5: async reset mid-XFER (k=13, word 1 presented)
    for (int k = 1; k < 13; k++) tick();
    chk("t5_pre_data", data_a, 1);
    trig_a = 0;
    rst = 1; #1;
    chk("t5_rst", {sp_a, trg_a, aclk_a, data_a, ch_a, vld_a, busy_a, done_a, ovr_a}, 0);
    tick();
    rst = 0; trig_a = 1; tick();
    for (int k = 1; k <= 21; k++) begin
      if (k inside {10, 14, 18}) chk("t5_data", data_a, (k - 10) / 4);
      chk("t5_done", done_a, k == 20);
      chk("t5_ovr", ovr_a, 0);
      tick();
    end
    trig_a = 0;

    // 6: 4-bit word counter wraps
    trig_c = 1; tick();
    vc = 0; j = 0;
    for (int k = 1; k <= 81; k++) begin
      if (vld_c) vc++;
      if (k >= 10 && k <= 78 && ((k - 10) % 4) == 0) begin
        chk("t6_valid", vld_c, 1);
        chk("t6_data", data_c, j % 16);
        j++;
      end
      chk("t6_done", done_c, k == 80);
      tick();
    end
    trig_c = 0;
    chk("t6_nvalid", vc, 18);
    chk("t6_hold", data_c, 1);

    // zero delay: SP immediately after the edge
    trig_d = 1; tick();
    for (int k = 1; k <= 9; k++) begin
      chk("td_sp", sp_d, k <= 3);
      chk("td_trig", trg_d, k == 3);
      chk("td_done", done_d, k == 8);
      tick();
    end
    trig_d = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
